// File: rtl/vga_pixel_timing_if.sv
// rtl/vga_pixel_timing_if.sv - pixel-fetch and VGA output bundle for vga_pixel_timing
interface vga_pixel_timing_if #(
    parameter int XW         = 12,
    parameter int YW         = 11,
    parameter int COLOR_BITS = 1
);
    logic [XW-1:0]           x;
    logic [YW-1:0]           y;
    logic                    req;
    logic                    line_start;
    logic                    frame_start;
    logic [3*COLOR_BITS-1:0] pix_in;
    logic                    test_en;
    logic                    hsync;
    logic                    vsync;
    logic                    de;
    logic [COLOR_BITS-1:0]   red;
    logic [COLOR_BITS-1:0]   grn;
    logic [COLOR_BITS-1:0]   blu;

    modport master (
        input  pix_in, test_en,
        output x, y, req, line_start, frame_start,
        output hsync, vsync, de, red, grn, blu
    );

    modport slave (
        output pix_in, test_en,
        input  x, y, req, line_start, frame_start,
        input  hsync, vsync, de, red, grn, blu
    );
endinterface

// File: rtl/vga_pixel_timing.sv
// rtl/vga_pixel_timing.sv - parametrised VGA timing generator with latency-aligned pixel fetch
// Optional colour-bar test pattern is built when VGA_TEST_PATTERN_EN is defined.
module vga_pixel_timing #(
    parameter int width         = 1920,
    parameter int h_front_porch = 2048,
    parameter int h_sync_pulse  = 2256,
    parameter int h_back_porch  = 2600,
    parameter int height        = 1080,
    parameter int v_front_porch = 1081,
    parameter int v_sync_pulse  = 1084,
    parameter int v_back_porch  = 1500,
    parameter bit HS_POL        = 1'b1,
    parameter bit VS_POL        = 1'b1,
    parameter int COLOR_BITS    = 1,
    parameter int LAT           = 2
) (
    input  logic               clk,
    input  logic               reset,
    vga_pixel_timing_if.master bus
);
    localparam int XW = $clog2(h_back_porch);
    localparam int YW = $clog2(v_back_porch);
    localparam int CB = COLOR_BITS;

    localparam logic [XW-1:0] H_ACT  = XW'(width);
    localparam logic [XW-1:0] H_FP   = XW'(h_front_porch);
    localparam logic [XW-1:0] H_SP   = XW'(h_sync_pulse);
    localparam logic [XW-1:0] H_LAST = XW'(h_back_porch - 1);
    localparam logic [YW-1:0] V_ACT  = YW'(height);
    localparam logic [YW-1:0] V_FP   = YW'(v_front_porch);
    localparam logic [YW-1:0] V_SP   = YW'(v_sync_pulse);
    localparam logic [YW-1:0] V_LAST = YW'(v_back_porch - 1);

    if (!(width > 0 && width < h_front_porch && h_front_porch < h_sync_pulse &&
          h_sync_pulse < h_back_porch)) begin : g_bad_h
        $error("vga_pixel_timing: horizontal timing must be strictly increasing");
    end
    if (!(height > 0 && height < v_front_porch && v_front_porch < v_sync_pulse &&
          v_sync_pulse < v_back_porch)) begin : g_bad_v
        $error("vga_pixel_timing: vertical timing must be strictly increasing");
    end
    if (LAT < 0 || LAT > 15) begin : g_bad_lat
        $error("vga_pixel_timing: LAT must be in 0..15");
    end

    logic [XW-1:0] h_cnt_q, h_cnt_d;
    logic [YW-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    logic active, hs_raw, vs_raw;
    assign active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hs_raw = (h_cnt_q >= H_FP) && (h_cnt_q < H_SP);
    assign vs_raw = (v_cnt_q >= V_FP) && (v_cnt_q < V_SP);

    // The pattern needs x at output time, so x rides the delay line with the flags.
`ifdef VGA_TEST_PATTERN_EN
    localparam int TW = 3 + XW;
    logic [TW-1:0] tap_in;
    assign tap_in = {h_cnt_q, active, hs_raw, vs_raw};
`else
    localparam int TW = 3;
    logic [TW-1:0] tap_in;
    assign tap_in = {active, hs_raw, vs_raw};
`endif

    logic [TW-1:0] tap_out;

    if (LAT == 0) begin : g_bypass
        assign tap_out = tap_in;
    end else begin : g_dly
        logic [TW-1:0] dly_q [LAT];
        logic [TW-1:0] dly_d [LAT];

        always_comb begin
            dly_d[0] = tap_in;
            for (int i = 1; i < LAT; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < LAT; i++) begin
                    dly_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < LAT; i++) begin
                    dly_q[i] <= dly_d[i];
                end
            end
        end

        assign tap_out = dly_q[LAT-1];
    end

    logic active_dl, hs_dl, vs_dl;
    assign {active_dl, hs_dl, vs_dl} = tap_out[2:0];

`ifdef VGA_TEST_PATTERN_EN
    logic [XW-1:0] x_dl;
    logic [2:0]    bar;
    assign x_dl = tap_out[TW-1:3];
    assign bar  = 3'({x_dl, 3'b000} / (XW+3)'(width));
`else
    logic unused_test_en;
    assign unused_test_en = bus.test_en;
`endif

    logic [3*CB-1:0] pixel;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            de_q, de_d;
    logic [3*CB-1:0] rgb_q, rgb_d;

    always_comb begin
        pixel = bus.pix_in;
`ifdef VGA_TEST_PATTERN_EN
        if (bus.test_en) begin
            pixel = {{CB{bar[2]}}, {CB{bar[1]}}, {CB{bar[0]}}};
        end
`endif
        hsync_d = hs_dl ? HS_POL : ~HS_POL;
        vsync_d = vs_dl ? VS_POL : ~VS_POL;
        de_d    = active_dl;
        rgb_d   = active_dl ? pixel : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
        end
    end

    assign bus.x           = h_cnt_q;
    assign bus.y           = v_cnt_q;
    assign bus.req         = active;
    assign bus.line_start  = (h_cnt_q == '0);
    assign bus.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.de          = de_q;
    assign bus.red         = rgb_q[3*CB-1:2*CB];
    assign bus.grn         = rgb_q[2*CB-1:CB];
    assign bus.blu         = rgb_q[CB-1:0];
endmodule

// File: tb/tb_vga_pixel_timing.sv
// tb/tb_vga_pixel_timing.sv - self-checking bench for vga_pixel_timing
// Four small-mode instances: LAT=2, LAT=0, inverted sync polarity, and a 16-wide pattern mode.
module tb_vga_pixel_timing;
    localparam int F  = 128;
    localparam int FD = 192;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vga_pixel_timing_if #(.XW(4), .YW(3), .COLOR_BITS(2)) ia ();
    vga_pixel_timing_if #(.XW(4), .YW(3), .COLOR_BITS(2)) ib ();
    vga_pixel_timing_if #(.XW(4), .YW(3), .COLOR_BITS(2)) ic ();
    vga_pixel_timing_if #(.XW(5), .YW(3), .COLOR_BITS(2)) id ();

    vga_pixel_timing #(.width(8), .h_front_porch(10), .h_sync_pulse(12), .h_back_porch(16),
        .height(4), .v_front_porch(5), .v_sync_pulse(6), .v_back_porch(8),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_BITS(2), .LAT(2))
        dut_a (.clk(clk), .reset(reset), .bus(ia));
    vga_pixel_timing #(.width(8), .h_front_porch(10), .h_sync_pulse(12), .h_back_porch(16),
        .height(4), .v_front_porch(5), .v_sync_pulse(6), .v_back_porch(8),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_BITS(2), .LAT(0))
        dut_b (.clk(clk), .reset(reset), .bus(ib));
    vga_pixel_timing #(.width(8), .h_front_porch(10), .h_sync_pulse(12), .h_back_porch(16),
        .height(4), .v_front_porch(5), .v_sync_pulse(6), .v_back_porch(8),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_BITS(2), .LAT(2))
        dut_c (.clk(clk), .reset(reset), .bus(ic));
    vga_pixel_timing #(.width(16), .h_front_porch(18), .h_sync_pulse(20), .h_back_porch(24),
        .height(4), .v_front_porch(5), .v_sync_pulse(6), .v_back_porch(8),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_BITS(2), .LAT(2))
        dut_d (.clk(clk), .reset(reset), .bus(id));

    int n_cmp = 0;
    int n_bad = 0;
    int e     = 0;
    bit ten_cur  = 1'b0;
    bit ten_used = 1'b0;

    logic [5:0] tab_a [F];
    logic [5:0] tab_b [F];
    logic [5:0] tab_c [F];
    logic [5:0] tab_d [FD];

    // Expected {hsync, vsync, de, red, grn, blu} for screen position index p (p<0: still reset-cleared).
    function automatic logic [8:0] exp_out(int p, int w, int hfp, int hsp, int ht,
                                           bit hpol, bit vpol, bit pat, logic [5:0] pix);
        int x, y, bi;
        logic a, hs, vs;
        logic [2:0] bar;
        logic [5:0] rgb;
        if (p < 0) return {~hpol, ~vpol, 7'b0};
        x   = p % ht;
        y   = (p / ht) % 8;
        a   = (x < w) && (y < 4);
        hs  = (x >= hfp) && (x < hsp);
        vs  = (y == 5);
        bi  = (x * 8) / w;
        bar = 3'(bi);
        rgb = !a ? 6'b0 : pat ? {{2{bar[2]}}, {2{bar[1]}}, {2{bar[0]}}} : pix;
        return {hs ? hpol : ~hpol, vs ? vpol : ~vpol, a, rgb};
    endfunction

    task automatic drive();
        ia.pix_in  = (e >= 2) ? tab_a[(e-2) % F]  : 6'($urandom);
        ib.pix_in  = tab_b[e % F];
        ic.pix_in  = (e >= 2) ? tab_c[(e-2) % F]  : 6'($urandom);
        id.pix_in  = (e >= 2) ? tab_d[(e-2) % FD] : 6'($urandom);
        ten_cur    = 1'($urandom);
        id.test_en = ten_cur;
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        ten_used = ten_cur;
        #1;
        drive();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        e = 0;
        drive();
    endtask

    task automatic test_reset();
        int k;
        logic [8:0] act;
        k = $urandom_range(20, 60);
        repeat (k) step();
        #2;
        reset = 1'b0;
        #1;
        act = {ia.hsync, ia.vsync, ia.de, ia.red, ia.grn, ia.blu};
        n_cmp++;
        if (act !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected %b", act, 9'b0);
        end
        n_cmp++;
        if ({ia.x, ia.y} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_xy: got x=%0d y=%0d expected 0 0", ia.x, ia.y);
        end
        n_cmp++;
        if ({ia.req, ia.line_start, ia.frame_start} !== 3'b111) begin
            n_bad++;
            $display("FAIL reset_strobes: got %b expected 111", {ia.req, ia.line_start, ia.frame_start});
        end
        n_cmp++;
        if ({ic.hsync, ic.vsync, ic.de} !== 3'b110) begin
            n_bad++;
            $display("FAIL reset_neg_pol: got %b expected 110", {ic.hsync, ic.vsync, ic.de});
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (ia.x !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_hold_x: got %0d expected 0", ia.x);
        end
        release_reset();
        for (int i = 1; i <= 5; i++) begin
            step();
            n_cmp++;
            if (ia.x !== 4'(i)) begin
                n_bad++;
                $display("FAIL reset_count_x: got %0d expected %0d", ia.x, i);
            end
        end
    endtask

    task automatic test_counters();
        int fs_cnt, xe, ye;
        logic [9:0] act, expv;
        fs_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            xe   = e % 16;
            ye   = (e / 16) % 8;
            expv = {4'(xe), 3'(ye), (xe < 8) && (ye < 4), xe == 0, (xe == 0) && (ye == 0)};
            act  = {ia.x, ia.y, ia.req, ia.line_start, ia.frame_start};
            if (ia.frame_start) fs_cnt++;
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL counters at e=%0d: got %b expected %b", e, act, expv);
            end
        end
        n_cmp++;
        if (fs_cnt != 2) begin
            n_bad++;
            $display("FAIL frame_start_count: got %0d expected 2", fs_cnt);
        end
    endtask

    task automatic wait_frame(input string tag);
        int guard;
        guard = 0;
        while (!(ia.x == 4'd0 && ia.y == 3'd0) && guard < 300) begin
            step();
            guard++;
        end
        n_cmp++;
        if (guard >= 300) begin
            n_bad++;
            $display("FAIL %s_frame_wait: got timeout after %0d cycles expected frame start", tag, guard);
        end
    endtask

    task automatic test_horizontal();
        int hs_first, hs_cnt, de_first, de_cnt, req_cnt;
        hs_first = -1; hs_cnt = 0; de_first = -1; de_cnt = 0; req_cnt = 0;
        wait_frame("horizontal");
        for (int k = 1; k <= 16; k++) begin
            if (ia.req) req_cnt++;
            step();
            if (ia.hsync) begin
                if (hs_first < 0) hs_first = k;
                hs_cnt++;
            end
            if (ia.de) begin
                if (de_first < 0) de_first = k;
                de_cnt++;
            end
        end
        n_cmp++;
        if (req_cnt != 8) begin n_bad++; $display("FAIL req_per_line: got %0d expected 8", req_cnt); end
        n_cmp++;
        if (hs_first != 13) begin n_bad++; $display("FAIL hsync_start: got %0d expected 13", hs_first); end
        n_cmp++;
        if (hs_cnt != 2) begin n_bad++; $display("FAIL hsync_width: got %0d expected 2", hs_cnt); end
        n_cmp++;
        if (de_first != 3) begin n_bad++; $display("FAIL de_start: got %0d expected 3", de_first); end
        n_cmp++;
        if (de_cnt != 8) begin n_bad++; $display("FAIL de_width: got %0d expected 8", de_cnt); end
    endtask

    task automatic test_frame();
        int vs_cnt, de_cnt, fs_cnt, de_bad;
        vs_cnt = 0; de_cnt = 0; fs_cnt = 0; de_bad = 0;
        wait_frame("frame");
        for (int k = 1; k <= 128; k++) begin
            if (ia.frame_start) fs_cnt++;
            step();
            if (ia.vsync) vs_cnt++;
            if (ia.de) de_cnt++;
            if (ia.de && k >= 3 && ((k - 3) / 16) >= 4) de_bad++;
        end
        n_cmp++;
        if (vs_cnt != 16) begin n_bad++; $display("FAIL vsync_width: got %0d expected 16", vs_cnt); end
        n_cmp++;
        if (de_cnt != 32) begin n_bad++; $display("FAIL de_per_frame: got %0d expected 32", de_cnt); end
        n_cmp++;
        if (fs_cnt != 1) begin n_bad++; $display("FAIL frame_start_per_frame: got %0d expected 1", fs_cnt); end
        n_cmp++;
        if (de_bad != 0) begin n_bad++; $display("FAIL de_in_blank_lines: got %0d expected 0", de_bad); end
    endtask

    task automatic test_latency();
        logic [8:0] act, expv;
        int p;
        for (int i = 0; i < 300; i++) begin
            step();
            p    = e - 3;
            expv = exp_out(p, 8, 10, 12, 16, 1'b1, 1'b1, 1'b0, (p >= 0) ? tab_a[p % F] : 6'b0);
            act  = {ia.hsync, ia.vsync, ia.de, ia.red, ia.grn, ia.blu};
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL lat2_out at e=%0d: got %b expected %b", e, act, expv);
            end
            p    = e - 1;
            expv = exp_out(p, 8, 10, 12, 16, 1'b1, 1'b1, 1'b0, tab_b[p % F]);
            act  = {ib.hsync, ib.vsync, ib.de, ib.red, ib.grn, ib.blu};
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL lat0_out at e=%0d: got %b expected %b", e, act, expv);
            end
        end
    endtask

    task automatic test_polarity();
        logic [8:0] act, expv;
        int p, hs_lo, vs_lo;
        hs_lo = 0; vs_lo = 0;
        wait_frame("polarity");
        for (int i = 0; i < 128; i++) begin
            step();
            p    = e - 3;
            expv = exp_out(p, 8, 10, 12, 16, 1'b0, 1'b0, 1'b0, (p >= 0) ? tab_c[p % F] : 6'b0);
            act  = {ic.hsync, ic.vsync, ic.de, ic.red, ic.grn, ic.blu};
            if (!ic.hsync) hs_lo++;
            if (!ic.vsync) vs_lo++;
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL neg_pol_out at e=%0d: got %b expected %b", e, act, expv);
            end
        end
        n_cmp++;
        if (hs_lo != 16) begin n_bad++; $display("FAIL neg_hsync_low_cycles: got %0d expected 16", hs_lo); end
        n_cmp++;
        if (vs_lo != 16) begin n_bad++; $display("FAIL neg_vsync_low_cycles: got %0d expected 16", vs_lo); end
    endtask

    task automatic test_pattern();
        logic [8:0] act, expv;
        int p;
        bit pat;
        for (int i = 0; i < 400; i++) begin
            step();
`ifdef VGA_TEST_PATTERN_EN
            pat = ten_used;
`else
            pat = 1'b0;
`endif
            p    = e - 3;
            expv = exp_out(p, 16, 18, 20, 24, 1'b1, 1'b1, pat, (p >= 0) ? tab_d[p % FD] : 6'b0);
            act  = {id.hsync, id.vsync, id.de, id.red, id.grn, id.blu};
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL pattern_out at e=%0d test_en=%0b: got %b expected %b", e, ten_used, act, expv);
            end
        end
    endtask

    task automatic test_back_to_back_reset();
        logic [8:0] act, expv;
        int p;
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(30, 200)) step();
            #2;
            reset = 1'b0;
            #1;
            act = {ia.hsync, ia.vsync, ia.de, ia.red, ia.grn, ia.blu};
            n_cmp++;
            if (act !== 9'b0 || ia.x !== 4'd0 || ia.y !== 3'd0) begin
                n_bad++;
                $display("FAIL midframe_reset: got out=%b x=%0d y=%0d expected 0 0 0", act, ia.x, ia.y);
            end
            repeat ($urandom_range(1, 3)) @(posedge clk);
            release_reset();
            for (int i = 0; i < 150; i++) begin
                step();
                p    = e - 3;
                expv = exp_out(p, 8, 10, 12, 16, 1'b1, 1'b1, 1'b0, (p >= 0) ? tab_a[p % F] : 6'b0);
                act  = {ia.hsync, ia.vsync, ia.de, ia.red, ia.grn, ia.blu};
                n_cmp++;
                if (act !== expv || ia.x !== 4'(e % 16)) begin
                    n_bad++;
                    $display("FAIL after_reset at e=%0d: got out=%b x=%0d expected out=%b x=%0d",
                             e, act, ia.x, expv, e % 16);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < F; i++) begin
            tab_a[i] = 6'($urandom);
            tab_b[i] = 6'($urandom);
            tab_c[i] = 6'($urandom);
        end
        for (int i = 0; i < FD; i++) tab_d[i] = 6'($urandom);
        ia.test_en = 1'b0;
        ib.test_en = 1'b0;
        ic.test_en = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        release_reset();

        test_reset();
        test_counters();
        test_horizontal();
        test_frame();
        test_latency();
        test_polarity();
        test_pattern();
        test_back_to_back_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
